// File: rtl/osc_ctrl_pkg.sv
// osc_ctrl_pkg: shared types and helpers for the HF oscillator sequencer
//   state_t    : sequencer states
//   DIV_W_DEF  : default HF divider field width
//   timer_w()  : timer width able to hold the longest timed interval
package osc_ctrl_pkg;

    typedef enum logic [2:0] {OFF, STARTUP, RUN, GATE, RECONF, HOLD} state_t;

    localparam int DIV_W_DEF = 8;

    function automatic int timer_w(input int settle, input int gate, input int holdoff);
        int m;
        m = (settle > gate) ? settle : gate;
        m = (holdoff > m) ? holdoff : m;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/osc_ctrl_timer.sv
// osc_ctrl_timer: loadable down-counter shared by all timed sequencer states
//   clk, rst : clock, async active-high reset
//   load     : load value this cycle
//   value    : interval in cycles (0 treated as 1)
//   expired  : 1-cycle pulse, the cycle before the edge that ends the interval
module osc_ctrl_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst)
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= (value == '0) ? W'(1) : value;
        else if (cnt != '0)
            cnt <= cnt - W'(1);

    // Loading X at edge n lets the owning state act on expiry at edge n+X.
    assign expired = (cnt == W'(1));

endmodule

// File: rtl/osc_ctrl_seq.sv
// osc_ctrl_seq: HF oscillator sequencer (power-up/settle, glitch-free divider change, power-down)
//   clk, rst    : system clock, async active-high reset
//   req         : per-requester level request
//   grant       : oscillator clock usable by requester i
//   div_req/val : divider change handshake, div_ack pulses when applied and settled
//   osc_en      : OSC_CORE HF enable
//   osc_div     : OSC_CORE HF divider
//   clk_gate_en : downstream clock gate enable
//   busy        : high in STARTUP, GATE, RECONF and HOLD
// Build option OSC_CTRL_HOLDOFF_EN: idle HOLD state delays power-down by HOLDOFF_CYC.
module osc_ctrl_seq
    import osc_ctrl_pkg::*;
#(
    parameter int               N_REQ       = 2,
    parameter int               DIV_W       = DIV_W_DEF,
    parameter logic [DIV_W-1:0] DIV_RESET   = DIV_W'(1),
    parameter int               SETTLE_CYC  = 16,
    parameter int               GATE_CYC    = 4,
    parameter int               HOLDOFF_CYC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    input  logic             div_req,
    input  logic [DIV_W-1:0] div_val,
    output logic             div_ack,
    output logic             osc_en,
    output logic [DIV_W-1:0] osc_div,
    output logic             clk_gate_en,
    output logic             busy
);

    localparam int TW = timer_w(SETTLE_CYC, GATE_CYC, HOLDOFF_CYC);

    state_t          state;
    logic            expired;
    logic            t_load;
    logic [TW-1:0]   t_val;
    logic            any_req;
    logic            div_pend;
    logic            div_diff;
    logic            to_gate;
    logic            to_hold;

    assign any_req  = |req;
    // An ack in flight closes the handshake; ignore the still-high div_req that cycle.
    assign div_pend = div_req & ~div_ack;
    assign div_diff = (div_val != osc_div);
    assign to_gate  = (state == RUN) & any_req & div_pend & div_diff;
`ifdef OSC_CTRL_HOLDOFF_EN
    assign to_hold  = (state == RUN) & ~any_req;
`else
    assign to_hold  = 1'b0;
`endif

    assign t_load = ((state == OFF) & any_req) | ((state == GATE) & expired) | to_gate | to_hold;
    assign t_val  = to_gate ? TW'(GATE_CYC) : to_hold ? TW'(HOLDOFF_CYC) : TW'(SETTLE_CYC);

    osc_ctrl_timer #(.W(TW)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (t_load),
        .value   (t_val),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= OFF;
            osc_en      <= 1'b0;
            osc_div     <= DIV_RESET;
            clk_gate_en <= 1'b0;
            grant       <= '0;
            div_ack     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            div_ack <= 1'b0;
            case (state)
                OFF:
                    // A new request takes priority; a pending divider change is served in RUN.
                    if (any_req) begin
                        state  <= STARTUP;
                        osc_en <= 1'b1;
                        busy   <= 1'b1;
                    end else if (div_pend) begin
                        osc_div <= div_val;
                        div_ack <= 1'b1;
                    end
                STARTUP:
                    if (expired) begin
                        state       <= RUN;
                        clk_gate_en <= 1'b1;
                        busy        <= 1'b0;
                    end
                RUN:
                    if (!any_req) begin
                        grant <= '0;
`ifdef OSC_CTRL_HOLDOFF_EN
                        state <= HOLD;
                        busy  <= 1'b1;
`else
                        state       <= OFF;
                        osc_en      <= 1'b0;
                        clk_gate_en <= 1'b0;
`endif
                    end else if (to_gate) begin
                        state       <= GATE;
                        clk_gate_en <= 1'b0;
                        grant       <= '0;
                        busy        <= 1'b1;
                    end else begin
                        grant   <= req;
                        div_ack <= div_pend;
                    end
                GATE:
                    if (expired) begin
                        state   <= RECONF;
                        osc_div <= div_val;
                    end
                RECONF:
                    if (expired) begin
                        state       <= RUN;
                        clk_gate_en <= 1'b1;
                        div_ack     <= 1'b1;
                        busy        <= 1'b0;
                    end
                HOLD:
                    if (any_req) begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end else if (expired) begin
                        state       <= OFF;
                        osc_en      <= 1'b0;
                        clk_gate_en <= 1'b0;
                        busy        <= 1'b0;
                    end
                default:
                    state <= OFF;
            endcase
        end
    end

endmodule

// File: tb/tb_osc_ctrl_seq.sv
// tb_osc_ctrl_seq: directed timeline checks plus randomized run against a behavioural model
module tb_osc_ctrl_seq;

    localparam int SETTLE  = 16;
    localparam int GATEC   = 4;
    localparam int HOLDOFF = 8;

    localparam int P_OFF = 0, P_WARM = 1, P_ON = 2, P_GATING = 3, P_SETTLING = 4, P_IDLE = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = '0;
    logic [1:0] grant;
    logic       div_req = 1'b0;
    logic [7:0] div_val = '0;
    logic       div_ack;
    logic       osc_en;
    logic [7:0] osc_div;
    logic       clk_gate_en;
    logic       busy;

    int total = 0;
    int bad = 0;

    int         m_phase;
    int         m_left;
    logic       m_on;
    logic [7:0] m_div;
    logic       m_gate;
    logic [1:0] m_grant;
    logic       m_ack;
    logic       m_busy;

    osc_ctrl_seq #(
        .N_REQ(2), .DIV_W(8), .DIV_RESET(8'd1),
        .SETTLE_CYC(SETTLE), .GATE_CYC(GATEC), .HOLDOFF_CYC(HOLDOFF)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .grant(grant),
        .div_req(div_req), .div_val(div_val), .div_ack(div_ack),
        .osc_en(osc_en), .osc_div(osc_div), .clk_gate_en(clk_gate_en), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_phase = P_OFF; m_left = 0; m_on = 0; m_div = 8'd1;
        m_gate = 0; m_grant = '0; m_ack = 0; m_busy = 0;
    endtask

    // One clock edge of the oscillator protocol, in terms of phases and remaining cycles.
    task automatic model_step();
        m_ack = 1'b0;
        case (m_phase)
            P_OFF:
                if (req != 0) begin m_on = 1; m_phase = P_WARM; m_left = SETTLE; end
                else if (div_req) begin m_div = div_val; m_ack = 1; end
            P_WARM: begin
                m_left--;
                if (m_left == 0) begin m_gate = 1; m_phase = P_ON; end
            end
            P_ON:
                if (req == 0) begin
                    m_grant = '0;
`ifdef OSC_CTRL_HOLDOFF_EN
                    m_phase = P_IDLE; m_left = HOLDOFF;
`else
                    m_phase = P_OFF; m_on = 0; m_gate = 0;
`endif
                end else if (div_req && div_val == m_div) begin
                    m_ack = 1; m_grant = req;
                end else if (div_req) begin
                    m_gate = 0; m_grant = '0; m_phase = P_GATING; m_left = GATEC;
                end else m_grant = req;
            P_GATING: begin
                m_left--;
                if (m_left == 0) begin m_div = div_val; m_phase = P_SETTLING; m_left = SETTLE; end
            end
            P_SETTLING: begin
                m_left--;
                if (m_left == 0) begin m_gate = 1; m_ack = 1; m_phase = P_ON; end
            end
            default:
                if (req != 0) m_phase = P_ON;
                else begin
                    m_left--;
                    if (m_left == 0) begin m_on = 0; m_gate = 0; m_phase = P_OFF; end
                end
        endcase
        m_busy = m_phase inside {P_WARM, P_GATING, P_SETTLING, P_IDLE};
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1; req = 0; div_req = 0; div_val = 0;
        model_reset();
        repeat (2) @(negedge clk);
        total++;
        if ({osc_en, osc_div, clk_gate_en, grant, div_ack, busy} !== {1'b0, 8'd1, 1'b0, 2'b00, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_values: got en=%b div=%0d gate=%b grant=%b ack=%b busy=%b, want 0 1 0 00 0 0",
                     osc_en, osc_div, clk_gate_en, grant, div_ack, busy);
        end
        rst = 0;
    endtask

    task automatic test_startup();
        req = 2'b01;
        cycle();
        total++;
        if (osc_en !== 1'b1 || clk_gate_en !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL startup_osc_en: got en=%b gate=%b busy=%b, want 1 0 1", osc_en, clk_gate_en, busy);
        end
        for (int i = 2; i <= 18; i++) begin
            cycle();
            if (i == 16) begin
                total++;
                if (clk_gate_en !== 1'b0) begin bad++; $display("FAIL startup_gate_early: got %b want 0", clk_gate_en); end
            end
            if (i == 17) begin
                total++;
                if (clk_gate_en !== 1'b1 || grant !== 2'b00) begin
                    bad++; $display("FAIL startup_gate_on: got gate=%b grant=%b want 1 00", clk_gate_en, grant);
                end
            end
            if (i == 18) begin
                total++;
                if (grant !== 2'b01 || busy !== 1'b0) begin
                    bad++; $display("FAIL startup_grant: got grant=%b busy=%b want 01 0", grant, busy);
                end
            end
        end
    endtask

    task automatic test_div_change();
        div_req = 1; div_val = 8'd4;
        cycle();
        total++;
        if (clk_gate_en !== 1'b0 || grant !== 2'b00 || osc_div !== 8'd1) begin
            bad++; $display("FAIL div_gate: got gate=%b grant=%b div=%0d want 0 00 1", clk_gate_en, grant, osc_div);
        end
        repeat (3) cycle();
        total++;
        if (osc_div !== 8'd1) begin bad++; $display("FAIL div_early: got %0d want 1", osc_div); end
        cycle();
        total++;
        if (osc_div !== 8'd4 || clk_gate_en !== 1'b0) begin
            bad++; $display("FAIL div_applied: got div=%0d gate=%b want 4 0", osc_div, clk_gate_en);
        end
        for (int i = 1; i <= 16; i++) begin
            cycle();
            if (i < 16 && div_ack !== 1'b0) begin
                total++; bad++; $display("FAIL div_ack_early: at %0d got 1 want 0", i);
            end
        end
        total++;
        if (div_ack !== 1'b1 || clk_gate_en !== 1'b1 || grant !== 2'b00) begin
            bad++; $display("FAIL div_ack: got ack=%b gate=%b grant=%b want 1 1 00", div_ack, clk_gate_en, grant);
        end
        div_req = 0;
        cycle();
        total++;
        if (grant !== 2'b01 || div_ack !== 1'b0) begin
            bad++; $display("FAIL div_grant_back: got grant=%b ack=%b want 01 0", grant, div_ack);
        end
    endtask

    task automatic test_div_same();
        div_req = 1; div_val = 8'd4;
        cycle();
        total++;
        if (div_ack !== 1'b1 || clk_gate_en !== 1'b1 || grant !== 2'b01) begin
            bad++; $display("FAIL same_ack: got ack=%b gate=%b grant=%b want 1 1 01", div_ack, clk_gate_en, grant);
        end
        div_req = 0;
        cycle();
        total++;
        if (div_ack !== 1'b0 || clk_gate_en !== 1'b1 || osc_div !== 8'd4) begin
            bad++; $display("FAIL same_after: got ack=%b gate=%b div=%0d want 0 1 4", div_ack, clk_gate_en, osc_div);
        end
    endtask

    task automatic test_powerdown();
        req = 2'b00;
`ifdef OSC_CTRL_HOLDOFF_EN
        cycle();
        total++;
        if (grant !== 2'b00 || osc_en !== 1'b1 || clk_gate_en !== 1'b1 || busy !== 1'b1) begin
            bad++; $display("FAIL hold_enter: got grant=%b en=%b gate=%b busy=%b want 00 1 1 1", grant, osc_en, clk_gate_en, busy);
        end
        repeat (4) cycle();
        req = 2'b10;
        cycle();
        total++;
        if (busy !== 1'b0 || osc_en !== 1'b1) begin
            bad++; $display("FAIL hold_return: got busy=%b en=%b want 0 1", busy, osc_en);
        end
        cycle();
        total++;
        if (grant !== 2'b10) begin bad++; $display("FAIL hold_grant: got %b want 10", grant); end
        req = 2'b00;
        for (int i = 1; i <= 9; i++) begin
            cycle();
            total++;
            if (osc_en !== (i < 9)) begin
                bad++; $display("FAIL hold_expiry: at %0d got en=%b want %b", i, osc_en, i < 9);
            end
        end
        total++;
        if (clk_gate_en !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL hold_off: got gate=%b busy=%b want 0 0", clk_gate_en, busy);
        end
`else
        cycle();
        total++;
        if (osc_en !== 1'b0 || clk_gate_en !== 1'b0 || grant !== 2'b00 || busy !== 1'b0) begin
            bad++; $display("FAIL off_now: got en=%b gate=%b grant=%b busy=%b want 0 0 00 0", osc_en, clk_gate_en, grant, busy);
        end
`endif
    endtask

    task automatic test_reset_mid_gate();
        req = 2'b01;
        repeat (18) cycle();
        div_req = 1; div_val = 8'd9;
        repeat (3) cycle();
        total++;
        if (clk_gate_en !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL gate_reached: got gate=%b busy=%b want 0 1", clk_gate_en, busy);
        end
        rst = 1; req = 0; div_req = 0;
        #1;
        model_reset();
        total++;
        if ({osc_en, osc_div, clk_gate_en, grant, div_ack, busy} !== {1'b0, 8'd1, 1'b0, 2'b00, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL async_reset: got en=%b div=%0d gate=%b grant=%b ack=%b busy=%b, want 0 1 0 00 0 0",
                     osc_en, osc_div, clk_gate_en, grant, div_ack, busy);
        end
        @(negedge clk);
        rst = 0;
        repeat (5) cycle();
        total++;
        if (osc_en !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL stay_off: got en=%b busy=%b want 0 0", osc_en, busy);
        end
    endtask

    task automatic test_div_off();
        div_req = 1; div_val = 8'd2;
        cycle();
        total++;
        if (osc_div !== 8'd2 || div_ack !== 1'b1 || osc_en !== 1'b0) begin
            bad++; $display("FAIL off_div: got div=%0d ack=%b en=%b want 2 1 0", osc_div, div_ack, osc_en);
        end
        div_req = 0;
        cycle();
        total++;
        if (div_ack !== 1'b0) begin bad++; $display("FAIL off_ack_pulse: got 1 want 0"); end
    endtask

    task automatic test_random();
        logic [7:0] prev_div;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) req = 2'($urandom);
            if (div_req && div_ack) div_req = 0;
            else if (!div_req && !div_ack && $urandom_range(23) == 0) begin
                div_req = 1; div_val = 8'($urandom_range(1, 3));
            end
            prev_div = osc_div;
            cycle();
            total++;
            if ({osc_en, osc_div, clk_gate_en, grant, div_ack, busy} !== {m_on, m_div, m_gate, m_grant, m_ack, m_busy}) begin
                bad++;
                $display("FAIL random_cycle %0d: got en=%b div=%0d gate=%b grant=%b ack=%b busy=%b, want %b %0d %b %b %b %b",
                         i, osc_en, osc_div, clk_gate_en, grant, div_ack, busy,
                         m_on, m_div, m_gate, m_grant, m_ack, m_busy);
            end
            if (clk_gate_en && osc_div !== prev_div) begin
                total++; bad++;
                $display("FAIL div_while_ungated %0d: got %0d want %0d", i, osc_div, prev_div);
            end
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_div_change();
        test_div_same();
        test_powerdown();
        test_reset_mid_gate();
        test_div_off();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
